// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: launches a SHA-256 core over an inclusive nonce range and stops on hit/exhaust/abort.
// Optional build macro NONCE_SWEEP_TIMEOUT_EN adds a per-hash watchdog and the timeout status output.
module nonce_sweep_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic         abort,
    input  logic [607:0] hdr,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         core_start,
    output logic [639:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         aborted,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  nonce_cur
`ifdef NONCE_SWEEP_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t         state, state_d;
    logic [607:0]   hdr_q;
    logic [31:0]    end_q;
    logic [255:0]   tgt_q;
    logic [255:0]   hash_q;
    logic           abort_pend;

    logic capture, launch, advance, take_hash;
    logic set_found, set_exh, set_abt, set_tmo;

    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef NONCE_SWEEP_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`endif

    assign core_block = {hdr_q, nonce_cur};
    assign busy       = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        capture   = 1'b0;
        launch    = 1'b0;
        advance   = 1'b0;
        take_hash = 1'b0;
        set_found = 1'b0;
        set_exh   = 1'b0;
        set_abt   = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    capture = 1'b1;
                    if (nonce_end < nonce_start) begin
                        set_exh = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    set_abt = 1'b1;
                    state_d = S_DONE;
                end else begin
                    launch  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An abort seen while the core runs only lands once its result arrives
                if (core_done) begin
                    if (abort_pend || abort) begin
                        set_abt = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        take_hash = 1'b1;
                        state_d   = S_CHECK;
                    end
                end
`ifdef NONCE_SWEEP_TIMEOUT_EN
                else if (tmo_cnt == TIMEOUT_CYCLES - 1) begin
                    set_tmo = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_CHECK: begin
                if (hash_q < tgt_q) begin
                    set_found = 1'b1;
                    state_d   = S_DONE;
                end else if (abort) begin
                    set_abt = 1'b1;
                    state_d = S_DONE;
                end else if (nonce_cur == end_q) begin
                    set_exh = 1'b1;
                    state_d = S_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_start  <= 1'b0;
            hdr_q       <= '0;
            end_q       <= '0;
            tgt_q       <= '0;
            hash_q      <= '0;
            abort_pend  <= 1'b0;
            nonce_cur   <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            aborted     <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else begin
            core_start <= launch;
            if (capture) begin
                hdr_q       <= hdr;
                end_q       <= nonce_end;
                tgt_q       <= target;
                nonce_cur   <= nonce_start;
                found       <= 1'b0;
                exhausted   <= set_exh;
                aborted     <= 1'b0;
                found_nonce <= '0;
                found_hash  <= '0;
                abort_pend  <= 1'b0;
            end else begin
                if (advance)   nonce_cur <= nonce_cur + 32'd1;
                if (take_hash) hash_q    <= core_hash;
                if (set_found) begin
                    found       <= 1'b1;
                    found_nonce <= nonce_cur;
                    found_hash  <= hash_q;
                end
                if (set_exh) exhausted <= 1'b1;
                if (set_abt) aborted   <= 1'b1;
                if (launch)
                    abort_pend <= 1'b0;
                else if (state == S_WAIT && abort)
                    abort_pend <= 1'b1;
            end
        end
    end

`ifdef NONCE_SWEEP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (launch)
                tmo_cnt <= '0;
            else if (state == S_WAIT)
                tmo_cnt <= tmo_cnt + 32'd1;
            if (capture)
                timeout <= 1'b0;
            else if (set_tmo)
                timeout <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = set_tmo;
`endif

endmodule
